// File: rtl/alu_operand_stage.sv
// Operand stage ahead of the ALU: 2**AW x DW register file with write-first bypass,
// shift-carry flag, and a stallable operand latch feeding the ALU inputs.
module alu_operand_stage #(
    parameter int unsigned DW  = 8,
    parameter int unsigned AW  = 3,
    parameter int unsigned OPW = 3
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           InValid,
    input  logic           Stall,
    input  logic [AW-1:0]  RaddrA,
    input  logic [AW-1:0]  RaddrB,
    input  logic [OPW-1:0] OpIn,
    input  logic           WriteEn,
    input  logic [AW-1:0]  Waddr,
    input  logic [DW-1:0]  DataIn,
    input  logic           SCWriteEn,
    input  logic           SCNext,
    output logic           OutValid,
    output logic [DW-1:0]  InputA,
    output logic [DW-1:0]  InputB,
    output logic [OPW-1:0] OP,
    output logic           SC_in
);

    localparam int unsigned NumRegs = 2 ** AW;

    logic [DW-1:0]  mem_q [NumRegs];
    logic           sc_q;
    logic           valid_q;
    logic [DW-1:0]  a_q;
    logic [DW-1:0]  b_q;
    logic [OPW-1:0] op_q;

    logic [DW-1:0]  rd_a;
    logic [DW-1:0]  rd_b;

    // Write-first: a writeback in this cycle is what the same-cycle read sees.
    always_comb begin
        rd_a = mem_q[RaddrA];
        rd_b = mem_q[RaddrB];
        if (WriteEn && (Waddr == RaddrA)) rd_a = DataIn;
        if (WriteEn && (Waddr == RaddrB)) rd_b = DataIn;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int unsigned i = 0; i < NumRegs; i++) begin
                mem_q[i] <= '0;
            end
            sc_q    <= 1'b0;
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
        end else begin
            if (WriteEn) mem_q[Waddr] <= DataIn;
            if (SCWriteEn) sc_q <= SCNext;
            if (!Stall) begin
                valid_q <= InValid;
                // Operands only move on a real instruction so the ALU inputs stay quiet.
                if (InValid) begin
                    a_q  <= rd_a;
                    b_q  <= rd_b;
                    op_q <= OpIn;
                end
            end
        end
    end

    assign OutValid = valid_q;
    assign InputA   = a_q;
    assign InputB   = b_q;
    assign OP       = op_q;
    assign SC_in    = sc_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios plus randomized traffic
// against a register-file model that applies each cycle's writeback before its reads.
module tb_alu_operand_stage;

    logic       Clk = 1'b0;
    logic       Reset, InValid, Stall, WriteEn, SCWriteEn, SCNext;
    logic [2:0] RaddrA, RaddrB, OpIn, Waddr;
    logic [7:0] DataIn;
    logic       OutValid, SC_in;
    logic [7:0] InputA, InputB;
    logic [2:0] OP;

    int total = 0;
    int bad   = 0;

    // Reference state
    logic [7:0] m_mem [8];
    logic       m_sc, m_v;
    logic [7:0] m_a, m_b;
    logic [2:0] m_op;

    always #5 Clk = ~Clk;

    alu_operand_stage #(.DW(8), .AW(3), .OPW(3)) dut (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .Stall(Stall),
        .RaddrA(RaddrA), .RaddrB(RaddrB), .OpIn(OpIn), .WriteEn(WriteEn),
        .Waddr(Waddr), .DataIn(DataIn), .SCWriteEn(SCWriteEn), .SCNext(SCNext),
        .OutValid(OutValid), .InputA(InputA), .InputB(InputB), .OP(OP), .SC_in(SC_in)
    );

    task automatic idle();
        Reset = 0; InValid = 0; Stall = 0; WriteEn = 0; SCWriteEn = 0; SCNext = 0;
        RaddrA = 0; RaddrB = 0; OpIn = 0; Waddr = 0; DataIn = 0;
    endtask

    // Advance the model by one clock from the current inputs, then clock the DUT.
    task automatic cycle();
        if (Reset) begin
            foreach (m_mem[i]) m_mem[i] = 8'h00;
            m_sc = 0; m_v = 0; m_a = 0; m_b = 0; m_op = 0;
        end else begin
            if (WriteEn) m_mem[Waddr] = DataIn;
            if (SCWriteEn) m_sc = SCNext;
            if (!Stall) begin
                m_v = InValid;
                if (InValid) begin
                    m_a = m_mem[RaddrA]; m_b = m_mem[RaddrB]; m_op = OpIn;
                end
            end
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        idle(); Reset = 1; cycle(); Reset = 0;
        total++;
        if ({OutValid, InputA, InputB, OP, SC_in} !== 21'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", {OutValid, InputA, InputB, OP, SC_in});
        end
        for (int i = 0; i < 8; i++) begin
            InValid = 1; RaddrA = 3'(i); RaddrB = 3'(7 - i); OpIn = 3'(i);
            cycle();
            total++;
            if ({OutValid, InputA, InputB, OP, SC_in} !== {1'b1, 8'h00, 8'h00, 3'(i), 1'b0}) begin
                bad++;
                $display("FAIL reset_read_r%0d got v=%b a=%h b=%h op=%0d sc=%b want 1/00/00/%0d/0",
                         i, OutValid, InputA, InputB, OP, SC_in, i);
            end
        end
        idle();
    endtask

    task automatic test_regs();
        idle();
        WriteEn = 1; Waddr = 3; DataIn = 8'h0F; cycle();
        Waddr = 5; DataIn = 8'hF0; cycle();
        WriteEn = 0; InValid = 1; RaddrA = 3; RaddrB = 5; OpIn = 3'b011; cycle();
        total++;
        if ({InputA, InputB, OP, OutValid} !== {8'h0F, 8'hF0, 3'b011, 1'b1}) begin
            bad++;
            $display("FAIL regs_read got a=%h b=%h op=%b v=%b want 0f/f0/011/1",
                     InputA, InputB, OP, OutValid);
        end
        // Idle cycle: valid drops, operands hold.
        InValid = 0; RaddrA = 0; RaddrB = 0; OpIn = 3'b111; cycle();
        total++;
        if ({InputA, InputB, OP, OutValid} !== {8'h0F, 8'hF0, 3'b011, 1'b0}) begin
            bad++;
            $display("FAIL idle_hold got a=%h b=%h op=%b v=%b want 0f/f0/011/0",
                     InputA, InputB, OP, OutValid);
        end
        idle();
    endtask

    task automatic test_bypass();
        idle();
        WriteEn = 1; Waddr = 2; DataIn = 8'hA5; InValid = 1; RaddrA = 2; RaddrB = 5; OpIn = 1;
        cycle();
        total++;
        if ({InputA, InputB} !== {8'hA5, 8'hF0}) begin
            bad++;
            $display("FAIL bypass got a=%h b=%h want a5/f0", InputA, InputB);
        end
        WriteEn = 0; RaddrA = 6; RaddrB = 2; cycle();
        total++;
        if ({InputA, InputB} !== {8'h00, 8'hA5}) begin
            bad++;
            $display("FAIL bypass_persist got a=%h b=%h want 00/a5", InputA, InputB);
        end
        idle();
    endtask

    task automatic test_stall();
        idle();
        InValid = 1; RaddrA = 3; RaddrB = 3; OpIn = 3'b110; cycle();
        total++;
        if ({InputA, InputB} !== {8'h0F, 8'h0F}) begin
            bad++;
            $display("FAIL stall_pre got a=%h b=%h want 0f/0f", InputA, InputB);
        end
        Stall = 1; WriteEn = 1; Waddr = 3; DataIn = 8'h55;
        for (int i = 0; i < 3; i++) begin
            RaddrA = 3'(i); OpIn = 3'(i); InValid = i[0];
            cycle();
            total++;
            if ({InputA, OP, OutValid} !== {8'h0F, 3'b110, 1'b1}) begin
                bad++;
                $display("FAIL stall_hold%0d got a=%h op=%b v=%b want 0f/110/1",
                         i, InputA, OP, OutValid);
            end
        end
        Stall = 0; WriteEn = 0; InValid = 1; RaddrA = 3; OpIn = 3'b110; cycle();
        total++;
        if ({InputA, OutValid} !== {8'h55, 1'b1}) begin
            bad++;
            $display("FAIL stall_release got a=%h v=%b want 55/1", InputA, OutValid);
        end
        idle();
    endtask

    task automatic test_sc();
        idle();
        SCWriteEn = 1; SCNext = 1; cycle();
        total++;
        if (SC_in !== 1'b1) begin bad++; $display("FAIL sc_set got=%b want=1", SC_in); end
        SCWriteEn = 0; SCNext = 0; cycle(); cycle();
        total++;
        if (SC_in !== 1'b1) begin bad++; $display("FAIL sc_hold got=%b want=1", SC_in); end
        SCWriteEn = 1; SCNext = 0; cycle();
        total++;
        if (SC_in !== 1'b0) begin bad++; $display("FAIL sc_clear got=%b want=0", SC_in); end
        Stall = 1; SCNext = 1; cycle();
        total++;
        if (SC_in !== 1'b1) begin bad++; $display("FAIL sc_stall got=%b want=1", SC_in); end
        idle();
    endtask

    task automatic test_reset_mid_stall();
        idle();
        InValid = 1; RaddrA = 3; RaddrB = 2; OpIn = 3'b101; cycle();
        Stall = 1; Reset = 1; WriteEn = 1; Waddr = 3; DataIn = 8'h77; SCWriteEn = 1; SCNext = 1;
        cycle();
        total++;
        if ({OutValid, InputA, InputB, OP, SC_in} !== 21'h0) begin
            bad++;
            $display("FAIL reset_mid_stall got=%h want=0", {OutValid, InputA, InputB, OP, SC_in});
        end
        idle(); InValid = 1; RaddrA = 3; RaddrB = 5; cycle();
        total++;
        if ({InputA, InputB, OutValid} !== {8'h00, 8'h00, 1'b1}) begin
            bad++;
            $display("FAIL reset_cleared_regs got a=%h b=%h v=%b want 00/00/1",
                     InputA, InputB, OutValid);
        end
        idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            Reset     = ($urandom_range(0, 99) == 0);
            InValid   = ($urandom_range(0, 3) != 0);
            Stall     = ($urandom_range(0, 3) == 0);
            WriteEn   = ($urandom_range(0, 1) == 1);
            SCWriteEn = ($urandom_range(0, 2) == 0);
            SCNext    = 1'($urandom);
            RaddrA    = 3'($urandom_range(0, 7));
            RaddrB    = 3'($urandom_range(0, 7));
            Waddr     = 3'($urandom_range(0, 7));
            OpIn      = 3'($urandom);
            DataIn    = 8'($urandom);
            cycle();
            total++;
            if ({OutValid, InputA, InputB, OP, SC_in} !== {m_v, m_a, m_b, m_op, m_sc}) begin
                bad++;
                $display("FAIL random%0d got v=%b a=%h b=%h op=%0d sc=%b want v=%b a=%h b=%h op=%0d sc=%b",
                         n, OutValid, InputA, InputB, OP, SC_in, m_v, m_a, m_b, m_op, m_sc);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        foreach (m_mem[i]) m_mem[i] = 8'h00;
        m_sc = 0; m_v = 0; m_a = 0; m_b = 0; m_op = 0;
        @(negedge Clk);
        test_reset();
        test_regs();
        test_bypass();
        test_stall();
        test_sc();
        test_reset_mid_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
